// File: rtl/mesi_ccu.sv
// mesi_ccu -- MESI coherence controller for four private L1 caches in front of a shared L2.
// It takes one processor request at a time, snoops the other cores, and returns the word
// from a snooping core, the requester's own line or L2. It pushes written lines to L2 and
// drives the next MESI state of every core (M=00, E=01, S=10, I=11).
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   read, write              processor request (level); write wins if both are high
//   cache_hit, cache_miss    requester's L1 lookup result, sampled when SNOOP is left
//   pr_addr, pr_data         request address ([3:2] word, [11:4] index) and write word
//   req_core                 requesting core (0..3 = core1..core4)
//   bs_respN, coreN_valid    snoop response of core N, counted only when valid
//   snoop_data               word supplied by a snooping core
//   cache_dataN              current line of core N
//   cache_state_coreN        current MESI state of core N
//   l2_ready, l2_data        L2 handshake and returned line
//   bs_req, l2_read_req, l2_write_req, write_data   bus / L2 requests and line to write
//   data_out_CCU             word returned to the processor
//   cache_upd_state_coreN    next MESI state of core N
//   CCU_index                index of the accepted request
//   start, CCU_ready         accept and completion pulses
//
// Build option
//   MESI_CCU_DIRTY_FLUSH_EN  when defined, a read snoop hit on a core in M also writes that
//                            core's line back to L2 before completing.
module mesi_ccu #(
  parameter int ADDR_W  = 32,
  parameter int WORD_W  = 32,
  parameter int LINE_W  = 128,
  parameter int INDEX_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic              cache_hit,
  input  logic              cache_miss,
  input  logic [ADDR_W-1:0] pr_addr,
  input  logic [WORD_W-1:0] pr_data,
  input  logic [1:0]        req_core,
  input  logic              bs_resp1,
  input  logic              bs_resp2,
  input  logic              bs_resp3,
  input  logic              bs_resp4,
  input  logic              core1_valid,
  input  logic              core2_valid,
  input  logic              core3_valid,
  input  logic              core4_valid,
  input  logic [WORD_W-1:0] snoop_data,
  input  logic [LINE_W-1:0] cache_data1,
  input  logic [LINE_W-1:0] cache_data2,
  input  logic [LINE_W-1:0] cache_data3,
  input  logic [LINE_W-1:0] cache_data4,
  input  logic [1:0]        cache_state_core1,
  input  logic [1:0]        cache_state_core2,
  input  logic [1:0]        cache_state_core3,
  input  logic [1:0]        cache_state_core4,
  input  logic              l2_ready,
  input  logic [LINE_W-1:0] l2_data,
  output logic              bs_req,
  output logic              l2_read_req,
  output logic              l2_write_req,
  output logic [LINE_W-1:0] write_data,
  output logic [WORD_W-1:0] data_out_CCU,
  output logic [1:0]        cache_upd_state_core1,
  output logic [1:0]        cache_upd_state_core2,
  output logic [1:0]        cache_upd_state_core3,
  output logic [1:0]        cache_upd_state_core4,
  output logic [INDEX_W-1:0] CCU_index,
  output logic              start,
  output logic              CCU_ready
);

  localparam logic [1:0] ST_M = 2'b00, ST_E = 2'b01, ST_S = 2'b10, ST_I = 2'b11;

  typedef enum logic [2:0] {IDLE, SNOOP, READ_L2, WRITE_L2, DONE} state_t;

  state_t     state;
  logic [1:0] core_q;   // latched requester
  logic [1:0] wsel_q;   // latched word select
  logic       wr_q;     // latched operation, 1 = write

  // per-core views of the flat port list
  logic [3:0]             bs_arr, vld_arr, resp;
  logic [3:0][LINE_W-1:0] line;
  logic [3:0][1:0]        cst, upd, snoop_upd;
  logic [LINE_W-1:0]      req_line, merged;

  assign bs_arr  = {bs_resp4, bs_resp3, bs_resp2, bs_resp1};
  assign vld_arr = {core4_valid, core3_valid, core2_valid, core1_valid};
  assign line    = {cache_data4, cache_data3, cache_data2, cache_data1};
  assign cst     = {cache_state_core4, cache_state_core3, cache_state_core2, cache_state_core1};

  assign cache_upd_state_core1 = upd[0];
  assign cache_upd_state_core2 = upd[1];
  assign cache_upd_state_core3 = upd[2];
  assign cache_upd_state_core4 = upd[3];

  // only the index and word select of the address matter here
  logic unused_addr_bits;
  assign unused_addr_bits = ^{pr_addr[ADDR_W-1:12], pr_addr[1:0]};

  assign req_line = line[core_q];

  always_comb begin
    // a core answering its own request is not a responder
    for (int n = 0; n < 4; n++)
      resp[n] = bs_arr[n] & vld_arr[n] & (2'(n) != core_q);

    merged = req_line;
    merged[wsel_q*WORD_W +: WORD_W] = pr_data;

    // cores outside the transaction echo their current state
    snoop_upd = cst;
    if (wr_q) begin
      for (int n = 0; n < 4; n++)
        if (resp[n]) snoop_upd[n] = ST_I;
      snoop_upd[core_q] = ST_M;
    end else if (|resp) begin
      for (int n = 0; n < 4; n++)
        if (resp[n]) snoop_upd[n] = ST_S;
      snoop_upd[core_q] = ST_S;
    end
  end

`ifdef MESI_CCU_DIRTY_FLUSH_EN
  logic       m_hit;
  logic [1:0] m_idx;
  // lowest-numbered responder holding the line modified
  always_comb begin
    m_hit = 1'b0;
    m_idx = 2'd0;
    for (int n = 3; n >= 0; n--)
      if (resp[n] && cst[n] == ST_M) begin
        m_hit = 1'b1;
        m_idx = 2'(n);
      end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      core_q       <= 2'd0;
      wsel_q       <= 2'd0;
      wr_q         <= 1'b0;
      bs_req       <= 1'b0;
      l2_read_req  <= 1'b0;
      l2_write_req <= 1'b0;
      write_data   <= '0;
      data_out_CCU <= '0;
      upd          <= {4{ST_I}};
      CCU_index    <= '0;
      start        <= 1'b0;
      CCU_ready    <= 1'b0;
    end else begin
      start     <= 1'b0;
      CCU_ready <= 1'b0;
      case (state)
        IDLE: if (read || write) begin
          core_q    <= req_core;
          wsel_q    <= pr_addr[3:2];
          wr_q      <= write;
          CCU_index <= pr_addr[11:4];
          start     <= 1'b1;
          bs_req    <= 1'b1;
          state     <= SNOOP;
        end
        SNOOP: begin
          upd <= snoop_upd;
          if (wr_q) begin
            // only a miss carries the new word; a hit line already holds it
            write_data   <= cache_miss ? merged : req_line;
            l2_write_req <= 1'b1;
            state        <= WRITE_L2;
          end else if (|resp) begin
            data_out_CCU <= snoop_data;
`ifdef MESI_CCU_DIRTY_FLUSH_EN
            if (m_hit) begin
              write_data   <= line[m_idx];
              l2_write_req <= 1'b1;
              state        <= WRITE_L2;
            end else begin
              CCU_ready <= 1'b1;
              state     <= DONE;
            end
`else
            CCU_ready <= 1'b1;
            state     <= DONE;
`endif
          end else if (cache_hit) begin
            data_out_CCU <= req_line[wsel_q*WORD_W +: WORD_W];
            CCU_ready    <= 1'b1;
            state        <= DONE;
          end else begin
            l2_read_req <= 1'b1;
            state       <= READ_L2;
          end
        end
        READ_L2: if (l2_ready) begin
          data_out_CCU <= l2_data[wsel_q*WORD_W +: WORD_W];
          upd[core_q]  <= ST_E;
          CCU_ready    <= 1'b1;
          state        <= DONE;
        end
        WRITE_L2: if (l2_ready) begin
          CCU_ready <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          bs_req       <= 1'b0;
          l2_read_req  <= 1'b0;
          l2_write_req <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mesi_ccu.sv
// tb_mesi_ccu -- randomized self-checking bench for mesi_ccu against a transaction-level
// model of the MESI rules (default build, no dirty flush).
module tb_mesi_ccu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, read, write, cache_hit, cache_miss, l2_ready;
  logic [31:0] pr_addr, pr_data, snoop_data;
  logic [1:0]  req_core;
  logic [127:0] l2_data;
  logic [3:0] bs, vld;
  logic [3:0][127:0] line;
  logic [3:0][1:0] cst;

  logic bs_req, l2_read_req, l2_write_req, start, CCU_ready;
  logic [127:0] write_data;
  logic [31:0]  data_out_CCU;
  logic [7:0]   CCU_index;
  logic [1:0]   u1, u2, u3, u4;
  logic [3:0][1:0] upd;
  assign upd = {u4, u3, u2, u1};

  mesi_ccu dut (
    .clk(clk), .rst(rst), .read(read), .write(write),
    .cache_hit(cache_hit), .cache_miss(cache_miss),
    .pr_addr(pr_addr), .pr_data(pr_data), .req_core(req_core),
    .bs_resp1(bs[0]), .bs_resp2(bs[1]), .bs_resp3(bs[2]), .bs_resp4(bs[3]),
    .core1_valid(vld[0]), .core2_valid(vld[1]), .core3_valid(vld[2]), .core4_valid(vld[3]),
    .snoop_data(snoop_data),
    .cache_data1(line[0]), .cache_data2(line[1]), .cache_data3(line[2]), .cache_data4(line[3]),
    .cache_state_core1(cst[0]), .cache_state_core2(cst[1]),
    .cache_state_core3(cst[2]), .cache_state_core4(cst[3]),
    .l2_ready(l2_ready), .l2_data(l2_data),
    .bs_req(bs_req), .l2_read_req(l2_read_req), .l2_write_req(l2_write_req),
    .write_data(write_data), .data_out_CCU(data_out_CCU),
    .cache_upd_state_core1(u1), .cache_upd_state_core2(u2),
    .cache_upd_state_core3(u3), .cache_upd_state_core4(u4),
    .CCU_index(CCU_index), .start(start), .CCU_ready(CCU_ready)
  );

  int checks = 0, failures = 0;
  // model state: last word returned and last line written survive across transactions
  logic [31:0]  m_dout;
  logic [127:0] m_wd;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_reqs"}, {bs_req, l2_read_req, l2_write_req, start, CCU_ready}, 0);
    chk({tag, "_data"}, {write_data, data_out_CCU, CCU_index}, 0);
    chk({tag, "_upd"}, upd, 8'hFF);
  endtask

  task automatic do_reset();
    rst = 1'b1; read = 1'b0; write = 1'b0; l2_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    m_dout = '0;
    m_wd   = '0;
  endtask

  // One request end to end; bs/vld/line/cst/snoop_data/l2_data must be set by the caller.
  task automatic run_txn(input bit wr, input bit hit, input logic [1:0] rc,
                         input logic [31:0] addr, input logic [31:0] wdat, input int dly);
    logic [3:0] rsp;
    logic [3:0][1:0] e_upd;
    bit use_l2, direct, seen;
    int w, n_cyc;
    w = int'(addr[3:2]);
    rsp = bs & vld;
    rsp[rc] = 1'b0;
    e_upd = cst;
    use_l2 = 0; direct = 0;
    if (wr) begin
      for (int n = 0; n < 4; n++) if (rsp[n]) e_upd[n] = 2'b11;
      e_upd[rc] = 2'b00;
      m_wd = line[rc];
      if (!hit) m_wd[w*32 +: 32] = wdat;
    end else if (rsp != 0) begin
      for (int n = 0; n < 4; n++) if (rsp[n]) e_upd[n] = 2'b10;
      e_upd[rc] = 2'b10;
      m_dout = snoop_data;
      direct = 1;
    end else if (hit) begin
      m_dout = line[rc][w*32 +: 32];
      direct = 1;
    end else begin
      e_upd[rc] = 2'b01;
      m_dout = l2_data[w*32 +: 32];
      use_l2 = 1;
    end

    @(negedge clk);
    read = !wr; write = wr;
    cache_hit = hit; cache_miss = !hit;
    req_core = rc; pr_addr = addr; pr_data = wdat; l2_ready = 1'b0;
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      if (start) seen = 1;
    end
    chk("start", seen, 1);
    if (!seen) begin do_reset(); return; end
    chk("index", CCU_index, addr[11:4]);
    chk("bs_req", bs_req, 1);
    // the address is latched at accept; scrambling it must not matter
    read = 1'b0; write = 1'b0; pr_addr = $urandom;

    n_cyc = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (i >= dly) l2_ready = 1'b1;
      @(negedge clk);
      n_cyc++;
      if (CCU_ready) seen = 1;
    end
    chk("done", seen, 1);
    if (!seen) begin do_reset(); return; end
    if (direct) chk("latency", n_cyc, 1);
    chk("dout", data_out_CCU, m_dout);
    chk("upd", upd, e_upd);
    chk("wdata", write_data, m_wd);
    chk("l2rd", l2_read_req, use_l2);
    chk("l2wr", l2_write_req, wr);
    chk("bs_done", bs_req, 1);
    chk("index_hold", CCU_index, addr[11:4]);
    @(negedge clk);
    chk("idle", {bs_req, l2_read_req, l2_write_req, CCU_ready, start}, 0);
    l2_ready = 1'b0;
  endtask

  initial begin
    read = 0; write = 0; cache_hit = 0; cache_miss = 1; pr_addr = 0; pr_data = 0;
    req_core = 0; bs = 0; vld = 0; snoop_data = 0; line = '0; cst = {4{2'b11}};
    l2_ready = 0; l2_data = '0; rst = 1;
    do_reset();

    // read miss, core2 supplies the word
    bs = 4'b0010; vld = 4'b0010; snoop_data = 32'hAAAABBBB; cst = {2'b11, 2'b11, 2'b01, 2'b11};
    run_txn(0, 0, 2'd0, 32'h1234, 32'h0, 0);

    // write hit from core1, clean line goes to L2 untouched
    bs = 0; vld = 0;
    line[0] = 128'h11112222_33334444_55556666_77778888;
    run_txn(1, 1, 2'd0, 32'h1234, 32'hFFFF0000, 0);

    // read miss, no snoop -> L2 word 1, requester E
    l2_data = 128'hDEADBEEF_CAFEF00D_DEADBEEF_CAFEF00D;
    run_txn(0, 0, 2'd0, 32'h1234, 32'h0, 1);

    // core2 reads, core3 holds E -> both S
    bs = 4'b0100; vld = 4'b0100; cst = {2'b11, 2'b01, 2'b11, 2'b11}; snoop_data = 32'h5A5A1234;
    run_txn(0, 0, 2'd1, 32'h40, 32'h0, 0);

    // read miss at word 2
    bs = 0; vld = 0;
    l2_data = 128'hAAAABBBB_CCCCDDDD_12345678_9ABCDEF0;
    run_txn(0, 0, 2'd0, 32'h5678, 32'h0, 2);

    // response without valid is ignored -> L2 path
    bs = 4'b0110; vld = 4'b0010;
    run_txn(0, 0, 2'd1, 32'h5670, 32'h0, 0);

    // write miss merges pr_data into word 3
    bs = 0; vld = 0; line[2] = {4{32'h01020304}};
    run_txn(1, 0, 2'd2, 32'h0ABC, 32'hBEEFBEEF, 3);

    // core4 writes, core2 invalidated, then reset lands in WRITE_L2
    bs = 4'b0010; vld = 4'b0010; cst = {2'b11, 2'b11, 2'b10, 2'b11};
    @(negedge clk);
    write = 1; read = 0; cache_hit = 1; cache_miss = 0; req_core = 2'd3;
    pr_addr = 32'h2220; l2_ready = 0;
    @(negedge clk);
    chk("rst_start", start, 1);
    write = 0;
    @(negedge clk);
    chk("rst_l2wr", l2_write_req, 1);
    chk("rst_upd", upd, {2'b00, 2'b11, 2'b11, 2'b11});
    @(negedge clk);
    chk("rst_hold", {l2_write_req, CCU_ready}, 2'b10);
    rst = 1;
    @(negedge clk);
    chk_reset("midrst");
    rst = 0;
    m_dout = '0; m_wd = '0;

    // random traffic
    for (int t = 0; t < 80; t++) begin
      bs  = 4'($urandom);
      vld = 4'($urandom);
      for (int n = 0; n < 4; n++) begin
        line[n] = {$urandom, $urandom, $urandom, $urandom};
        cst[n]  = 2'($urandom);
      end
      snoop_data = $urandom;
      l2_data = {$urandom, $urandom, $urandom, $urandom};
      run_txn(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
              2'($urandom), $urandom, $urandom, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
